// File: rtl/flag_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : flag_unit_pkg
// Description : Opcodes, flag bit indices and write-mask encodings shared by
//               the flag producer and its combinational calculator.
// Revision    : 1.0 - initial release
// ============================================================================
package flag_unit_pkg;

    localparam logic [3:0] ADD = 4'b0000;
    localparam logic [3:0] SUB = 4'b0001;
    localparam logic [3:0] XOR = 4'b0010;
    localparam logic [3:0] SLL = 4'b0100;
    localparam logic [3:0] SRA = 4'b0101;
    localparam logic [3:0] ROR = 4'b0110;

    localparam int FLAG_N = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_Z = 0;

    localparam logic [2:0] MASK_NVZ  = 3'b111;
    localparam logic [2:0] MASK_Z    = 3'b001;
    localparam logic [2:0] MASK_NONE = 3'b000;

    // Which architectural flags an opcode is allowed to update.
    function automatic logic [2:0] op_mask(input logic [3:0] op);
        logic [2:0] m;
        case (op)
            ADD, SUB:           m = MASK_NVZ;
            XOR, SLL, SRA, ROR: m = MASK_Z;
            default:            m = MASK_NONE;
        endcase
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/flag_unit_calc.sv
`default_nettype none
// ============================================================================
// Module      : flag_calc
// Description : Combinational N/V/Z computation and write mask per ALU op.
// Revision    : 1.0 - initial release
// ============================================================================
module flag_calc
    import flag_unit_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    input  logic [DATA_W-1:0] raw_result,
    input  logic [DATA_W-1:0] result,
    output logic [2:0]        mask,
    output logic [2:0]        flags
);

    logic w_sign_a;
    logic w_sign_b;
    logic w_sign_raw;
    logic w_unused_bits;

    assign w_sign_a   = op_a[DATA_W-1];
    assign w_sign_b   = op_b[DATA_W-1];
    assign w_sign_raw = raw_result[DATA_W-1];

    // Only operand sign bits matter for overflow detection.
    assign w_unused_bits = &{1'b0, op_a[DATA_W-2:0], op_b[DATA_W-2:0],
                             raw_result[DATA_W-2:0]};

    always_comb begin
        flags         = 3'b000;
        flags[FLAG_Z] = (result == '0);
        flags[FLAG_N] = result[DATA_W-1];
        case (op)
            ADD:     flags[FLAG_V] = (w_sign_a == w_sign_b) && (w_sign_raw != w_sign_a);
            SUB:     flags[FLAG_V] = (w_sign_a != w_sign_b) && (w_sign_raw != w_sign_a);
            default: flags[FLAG_V] = 1'b0;
        endcase
        mask = op_mask(op);
    end

endmodule
`default_nettype wire

// File: rtl/flag_unit.sv
`default_nettype none
// ============================================================================
// Module      : flag_unit
// Description : Stages computed N/V/Z updates one cycle, then commits them
//               under write mask to the architectural flag register.
// Revision    : 1.0 - initial release
// ============================================================================
module flag_unit
    import flag_unit_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    input  logic [3:0]        alu_op,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    input  logic [DATA_W-1:0] raw_result,
    input  logic [DATA_W-1:0] result,
    input  logic              stall,
    input  logic              flush,
    output logic [2:0]        flags,
    output logic              flags_busy
);

    logic [2:0] w_mask;
    logic [2:0] w_calc_flags;

    logic       r_stage_valid;
    logic [2:0] r_stage_mask;
    logic [2:0] r_stage_flags;
    logic [2:0] r_flags;

    flag_calc #(
        .DATA_W (DATA_W)
    ) u_calc (
        .op         (alu_op),
        .op_a       (op_a),
        .op_b       (op_b),
        .raw_result (raw_result),
        .result     (result),
        .mask       (w_mask),
        .flags      (w_calc_flags)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stage_valid <= 1'b0;
            r_stage_mask  <= MASK_NONE;
            r_stage_flags <= 3'b000;
            r_flags       <= 3'b000;
        end else if (flush) begin
            r_stage_valid <= 1'b0;
        end else if (!stall) begin
            // Commit of the old entry and capture of the new one share an edge.
            if (r_stage_valid) begin
                r_flags <= (r_flags & ~r_stage_mask) | (r_stage_flags & r_stage_mask);
            end
            r_stage_valid <= alu_valid && (w_mask != MASK_NONE);
            if (alu_valid) begin
                r_stage_mask  <= w_mask;
                r_stage_flags <= w_calc_flags;
            end
        end
    end

    assign flags      = r_flags;
    assign flags_busy = r_stage_valid;

endmodule
`default_nettype wire
